// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: command, sample, RAM and transmitter signals of the capture sequencer.
// master is the sequencer side, slave is the surrounding UART/RAM/sample source.
interface capture_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              iRxDone;
    logic [7:0]        iRxData;
    logic              iSampleValid;
    logic [DATA_W-1:0] iSampleData;
    logic              oMemWrite;
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemWData;
    logic [DATA_W-1:0] iMemRData;
    logic              oTxStart;
    logic [7:0]        oTxData;
    logic              iTxDone;
    logic              oBusy;
    logic              oDone;
    logic              oAborted;

    modport master (
        input  iRxDone, iRxData, iSampleValid, iSampleData, iMemRData, iTxDone,
        output oMemWrite, oMemAddr, oMemWData, oTxStart, oTxData, oBusy, oDone, oAborted
    );

    modport slave (
        output iRxDone, iRxData, iSampleValid, iSampleData, iMemRData, iTxDone,
        input  oMemWrite, oMemAddr, oMemWData, oTxStart, oTxData, oBusy, oDone, oAborted
    );
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer: command-driven capture of DEPTH samples into RAM and MSB-first bytewise
// streaming of RAM words to a UART transmitter, abortable by ESC.
module capture_sequencer #(
    parameter int         DATA_W      = 8,
    parameter int         ADDR_W      = 4,
    parameter int         DEPTH       = 16,
    parameter logic [7:0] CMD_CAPTURE = 8'h63,
    parameter logic [7:0] CMD_SAMPLE  = 8'h73,
    parameter logic [7:0] CMD_DUMP    = 8'h64,
    parameter logic [7:0] CMD_ABORT   = 8'h1B
) (
    input logic                 iClock,
    input logic                 iReset_n,
    capture_sequencer_if.master bus
);
    localparam int BYTES = (DATA_W + 7) / 8;
    localparam int SW    = BYTES * 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [BW-1:0]     TOP  = BW'(BYTES - 1);

    typedef enum logic [2:0] {IDLE, SAMPLING, READ, LOAD, SEND, WAIT_TX} state_t;

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_cnt, w_cnt, r_addr, w_addr;
    logic [BW-1:0]     r_byte, w_byte;
    logic [SW-1:0]     r_shift, w_shift;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [7:0]        r_txd, w_txd;
    logic              r_auto, w_auto, r_wr, w_wr, r_start, w_start;
    logic              r_done, w_done, r_aborted, w_aborted, r_busy;
    logic              w_esc;

    assign w_esc = bus.iRxDone && (bus.iRxData == CMD_ABORT) && (r_state != IDLE);

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_byte    = r_byte;
        w_shift   = r_shift;
        w_auto    = r_auto;
        w_wdata   = r_wdata;
        w_txd     = r_txd;
        w_wr      = 1'b0;
        w_start   = 1'b0;
        w_done    = 1'b0;
        w_aborted = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.iRxDone && (bus.iRxData == CMD_CAPTURE || bus.iRxData == CMD_SAMPLE)) begin
                    w_state = SAMPLING;
                    w_auto  = bus.iRxData == CMD_CAPTURE;
                    w_cnt   = '0;
                end else if (bus.iRxDone && bus.iRxData == CMD_DUMP) begin
                    w_state = READ;
                    w_cnt   = '0;
                end
            end
            SAMPLING: begin
                if (bus.iSampleValid) begin
                    w_wr    = 1'b1;
                    w_wdata = bus.iSampleData;
                    w_cnt   = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                    w_state = (r_cnt != LAST) ? SAMPLING : (r_auto ? READ : IDLE);
                    w_done  = (r_cnt == LAST) && !r_auto;
                end
            end
            // The shared address bus still carries the final write; read it one cycle later.
            READ:    w_state = r_wr ? READ : LOAD;
            LOAD: begin
                w_shift = SW'(bus.iMemRData);
                w_byte  = TOP;
                w_state = SEND;
            end
            SEND: begin
                w_start = 1'b1;
                w_txd   = r_shift[r_byte*8 +: 8];
                w_state = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.iTxDone) begin
                    w_byte  = (r_byte != '0) ? r_byte - 1'b1 : r_byte;
                    w_cnt   = (r_byte == '0 && r_cnt != LAST) ? r_cnt + 1'b1 : r_cnt;
                    w_state = (r_byte != '0) ? SEND : ((r_cnt != LAST) ? READ : IDLE);
                    w_done  = (r_byte == '0) && (r_cnt == LAST);
                end
            end
            default: w_state = IDLE;
        endcase
        if (w_esc) begin
            w_state   = IDLE;
            w_cnt     = r_cnt;
            w_wr      = 1'b0;
            w_start   = 1'b0;
            w_done    = 1'b0;
            w_aborted = 1'b1;
        end
        w_addr = w_wr ? r_cnt : w_cnt;
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_byte    <= '0;
            r_shift   <= '0;
            r_wdata   <= '0;
            r_txd     <= '0;
            r_auto    <= 1'b0;
            r_wr      <= 1'b0;
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_addr    <= w_addr;
            r_byte    <= w_byte;
            r_shift   <= w_shift;
            r_wdata   <= w_wdata;
            r_txd     <= w_txd;
            r_auto    <= w_auto;
            r_wr      <= w_wr;
            r_start   <= w_start;
            r_done    <= w_done;
            r_aborted <= w_aborted;
            r_busy    <= w_state != IDLE;
        end
    end

    assign bus.oMemWrite = r_wr;
    assign bus.oMemAddr  = r_addr;
    assign bus.oMemWData = r_wdata;
    assign bus.oTxStart  = r_start;
    assign bus.oTxData   = r_txd;
    assign bus.oBusy     = r_busy;
    assign bus.oDone     = r_done;
    assign bus.oAborted  = r_aborted;
endmodule
